// File: rtl/seven_seg_pkg.sv
// Shared types and active-low segment codes for the multiplexed seven-segment driver.
package seven_seg_pkg;

    localparam int unsigned SEG_W       = 7;
    localparam int unsigned DIGIT_IDX_W = 2;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned BCD_W       = 10;

    typedef logic [SEG_W-1:0] seg_t;

    typedef enum logic [DIGIT_IDX_W-1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2,
        DIG_SIGN     = 2'd3
    } digit_e;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_E     = 7'b0000110;
    localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble to active-low segment decoder; non-BCD nibbles render as 'E'.
module seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    input  logic       dash_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_BLANK;
        if (dash_i) begin
            seg_n_o = SEG_DASH;
        end else if (!blank_i) begin
            case (nibble_i)
                4'd0:    seg_n_o = SEG_0;
                4'd1:    seg_n_o = SEG_1;
                4'd2:    seg_n_o = SEG_2;
                4'd3:    seg_n_o = SEG_3;
                4'd4:    seg_n_o = SEG_4;
                4'd5:    seg_n_o = SEG_5;
                4'd6:    seg_n_o = SEG_6;
                4'd7:    seg_n_o = SEG_7;
                4'd8:    seg_n_o = SEG_8;
                4'd9:    seg_n_o = SEG_9;
                default: seg_n_o = SEG_E;
            endcase
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// 4-digit common-anode scan driver: double-buffered BCD, leading-zero blanking,
// per-slot anti-ghosting blank window, frame reload only at the 3->0 digit wrap.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 200
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [9:0] bcd_in,
    input  logic       neg_in,
    input  logic       bcd_valid,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       frame_start
);

    localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END = PRESC_W'(BLANK_CYCLES);

    logic [PRESC_W-1:0] presc_q, presc_d;
    digit_e             idx_q, idx_d;
    logic [BCD_W-1:0]   pend_q, pend_d;
    logic               pend_neg_q, pend_neg_d;
    logic               pend_flag_q, pend_flag_d;
    logic [BCD_W-1:0]   act_q, act_d;
    logic               act_neg_q, act_neg_d;
    logic [3:0]         an_n_q, an_n_d;
    seg_t               seg_n_q, seg_n_d;
    logic               frame_start_q, frame_start_d;

    logic               tick_c;
    logic               wrap_c;
    logic [3:0]         digit_nib_c;
    logic               digit_blank_c;
    logic               digit_dash_c;
    logic [6:0]         seg_c;

    assign tick_c = (presc_q == PRESC_MAX);
    assign wrap_c = tick_c && (idx_q == DIG_SIGN);

    // Digit mux off the active buffer, feeding the single shared decoder.
    always_comb begin
        digit_nib_c   = act_q[3:0];
        digit_blank_c = 1'b0;
        digit_dash_c  = 1'b0;
        case (idx_q)
            DIG_ONES: begin
                digit_nib_c = act_q[3:0];
            end
            DIG_TENS: begin
                digit_nib_c   = act_q[7:4];
                digit_blank_c = (act_q[9:8] == 2'd0) && (act_q[7:4] == 4'd0);
            end
            DIG_HUNDREDS: begin
                digit_nib_c   = {2'b00, act_q[9:8]};
                digit_blank_c = (act_q[9:8] == 2'd0);
            end
            default: begin
                digit_blank_c = 1'b1;
                digit_dash_c  = act_neg_q;
            end
        endcase
    end

    seg_decode u_seg_decode (
        .nibble_i (digit_nib_c),
        .blank_i  (digit_blank_c),
        .dash_i   (digit_dash_c),
        .seg_n_o  (seg_c)
    );

    // Next-state: prescaler/index scan, buffer management, registered outputs.
    always_comb begin
        presc_d       = presc_q + PRESC_W'(1);
        idx_d         = idx_q;
        pend_d        = pend_q;
        pend_neg_d    = pend_neg_q;
        pend_flag_d   = pend_flag_q;
        act_d         = act_q;
        act_neg_d     = act_neg_q;
        an_n_d        = 4'b1111;
        seg_n_d       = SEG_BLANK;
        frame_start_d = 1'b0;

        if (tick_c) begin
            presc_d = '0;
            idx_d   = digit_e'(DIGIT_IDX_W'(idx_q + 1'b1));
        end

        // A strobe on the wrap tick goes straight to the active buffer.
        if (wrap_c) begin
            if (bcd_valid) begin
                act_d         = bcd_in;
                act_neg_d     = neg_in;
                pend_flag_d   = 1'b0;
                frame_start_d = 1'b1;
            end else if (pend_flag_q) begin
                act_d         = pend_q;
                act_neg_d     = pend_neg_q;
                pend_flag_d   = 1'b0;
                frame_start_d = 1'b1;
            end
        end else if (bcd_valid) begin
            pend_d      = bcd_in;
            pend_neg_d  = neg_in;
            pend_flag_d = 1'b1;
        end

        if (presc_q >= BLANK_END) begin
            an_n_d  = ~(4'b0001 << idx_q);
            seg_n_d = seg_c;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            presc_q       <= '0;
            idx_q         <= DIG_ONES;
            pend_q        <= '0;
            pend_neg_q    <= 1'b0;
            pend_flag_q   <= 1'b0;
            act_q         <= '0;
            act_neg_q     <= 1'b0;
            an_n_q        <= 4'b1111;
            seg_n_q       <= SEG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            pend_neg_q    <= pend_neg_d;
            pend_flag_q   <= pend_flag_d;
            act_q         <= act_d;
            act_neg_q     <= act_neg_d;
            an_n_q        <= an_n_d;
            seg_n_q       <= seg_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign an_n        = an_n_q;
    assign seg_n       = seg_n_q;
    assign frame_start = frame_start_q;

endmodule
